gemm_cmd_sequencer: RTL and testbench

- Engine-side responder for the controller's GEMM command interface.
- Accepts a single-cycle start pulse with M/K/N dimensions and flags, then owns busy for the whole operation.
- Splits the job into TILE×TILE×TILE sub-commands and issues them to the systolic array over a valid/ready handshake.
- Drops busy only after every issued tile has reported completion.

---
 rtl/npu_ctrl_pkg.sv | 37 +++
 rtl/tile_loop_counter.sv | 131 +++++++++++++
 rtl/gemm_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_gemm_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_ctrl_pkg.sv
// Shared NPU controller definitions: command opcodes, engine IDs, the tile
// command payload and the GEMM sequencer state encoding.
package npu_ctrl_pkg;

   localparam int unsigned OPC_W      = 8;
   localparam int unsigned ENG_ID_W   = 4;
   localparam int unsigned IMM_W      = 16;
   localparam int unsigned CMD_DIM_W  = 16;

   localparam logic [OPC_W-1:0]    OPC_NOP       = 8'h00;
   localparam logic [OPC_W-1:0]    OPC_GEMM      = 8'h01;
   localparam logic [OPC_W-1:0]    OPC_GEMM_ACC  = 8'h02;
   localparam logic [ENG_ID_W-1:0] ENG_ID_DMA    = 4'h1;
   localparam logic [ENG_ID_W-1:0] ENG_ID_GEMM   = 4'h2;

   // One sub-command for the systolic array; indices are in tile units.
   typedef struct packed {
      logic [CMD_DIM_W-1:0] m_idx;
      logic [CMD_DIM_W-1:0] n_idx;
      logic [CMD_DIM_W-1:0] k_idx;
      logic [CMD_DIM_W-1:0] m_len;
      logic [CMD_DIM_W-1:0] n_len;
      logic [CMD_DIM_W-1:0] k_len;
      logic                 accumulate;
      logic                 last_k;
      logic                 transpose_b;
      logic [IMM_W-1:0]     imm;
   } tile_cmd_t;

   typedef enum logic [1:0] {
      GS_IDLE   = 2'd0,
      GS_ISSUE  = 2'd1,
      GS_DRAIN  = 2'd2,
      GS_FINISH = 2'd3
   } gemm_seq_state_t;

endpackage

// File: rtl/tile_loop_counter.sv
// Nested m/n/k tile walker (k innermost, m outermost). All outputs are
// registered and describe the tile currently presented to the array.
module tile_loop_counter #(
   parameter int unsigned TILE      = 8,
   parameter int unsigned DIM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 advance,
   input  logic [DIM_WIDTH-1:0] dim_m,
   input  logic [DIM_WIDTH-1:0] dim_k,
   input  logic [DIM_WIDTH-1:0] dim_n,
   input  logic                 accumulate,
   output logic [DIM_WIDTH-1:0] m_idx,
   output logic [DIM_WIDTH-1:0] n_idx,
   output logic [DIM_WIDTH-1:0] k_idx,
   output logic [DIM_WIDTH-1:0] m_len,
   output logic [DIM_WIDTH-1:0] n_len,
   output logic [DIM_WIDTH-1:0] k_len,
   output logic                 tile_accumulate,
   output logic                 last_k,
   output logic                 last_tile
);

   localparam int unsigned SHIFT = $clog2(TILE);
   localparam int unsigned EXT_W = DIM_WIDTH + 1;

   // Index of the final tile along a dimension: ceil(d/TILE)-1.
   function automatic logic [DIM_WIDTH-1:0] last_idx(input logic [DIM_WIDTH-1:0] d);
      logic [EXT_W-1:0] cnt;
      cnt = (EXT_W'(d) + EXT_W'(TILE - 1)) >> SHIFT;
      return DIM_WIDTH'(cnt - EXT_W'(1));
   endfunction

   function automatic logic [DIM_WIDTH-1:0] len_of(input logic [DIM_WIDTH-1:0] idx,
                                                   input logic [DIM_WIDTH-1:0] last,
                                                   input logic [SHIFT-1:0]     rem);
      return ((idx == last) && (rem != '0)) ? DIM_WIDTH'(rem) : DIM_WIDTH'(TILE);
   endfunction

   logic [DIM_WIDTH-1:0] m_last_q, n_last_q, k_last_q;
   logic [DIM_WIDTH-1:0] m_last_c, n_last_c, k_last_c;
   logic [SHIFT-1:0]     m_rem_q, n_rem_q, k_rem_q;
   logic [SHIFT-1:0]     m_rem_c, n_rem_c, k_rem_c;
   logic                 acc_q, acc_c;
   logic [DIM_WIDTH-1:0] m_nx, n_nx, k_nx;

   // Bounds come straight from the inputs in the load cycle.
   always_comb begin
      m_last_c = m_last_q;
      n_last_c = n_last_q;
      k_last_c = k_last_q;
      m_rem_c  = m_rem_q;
      n_rem_c  = n_rem_q;
      k_rem_c  = k_rem_q;
      acc_c    = acc_q;
      if (load) begin
         m_last_c = last_idx(dim_m);
         n_last_c = last_idx(dim_n);
         k_last_c = last_idx(dim_k);
         m_rem_c  = dim_m[SHIFT-1:0];
         n_rem_c  = dim_n[SHIFT-1:0];
         k_rem_c  = dim_k[SHIFT-1:0];
         acc_c    = accumulate;
      end
   end

   // Next tile position.
   always_comb begin
      m_nx = m_idx;
      n_nx = n_idx;
      k_nx = k_idx;
      if (load) begin
         m_nx = '0;
         n_nx = '0;
         k_nx = '0;
      end else if (advance) begin
         if (k_idx == k_last_q) begin
            k_nx = '0;
            if (n_idx == n_last_q) begin
               n_nx = '0;
               m_nx = m_idx + DIM_WIDTH'(1);
            end else begin
               n_nx = n_idx + DIM_WIDTH'(1);
            end
         end else begin
            k_nx = k_idx + DIM_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_last_q        <= '0;
         n_last_q        <= '0;
         k_last_q        <= '0;
         m_rem_q         <= '0;
         n_rem_q         <= '0;
         k_rem_q         <= '0;
         acc_q           <= 1'b0;
         m_idx           <= '0;
         n_idx           <= '0;
         k_idx           <= '0;
         m_len           <= '0;
         n_len           <= '0;
         k_len           <= '0;
         tile_accumulate <= 1'b0;
         last_k          <= 1'b0;
         last_tile       <= 1'b0;
      end else if (load || advance) begin
         m_last_q        <= m_last_c;
         n_last_q        <= n_last_c;
         k_last_q        <= k_last_c;
         m_rem_q         <= m_rem_c;
         n_rem_q         <= n_rem_c;
         k_rem_q         <= k_rem_c;
         acc_q           <= acc_c;
         m_idx           <= m_nx;
         n_idx           <= n_nx;
         k_idx           <= k_nx;
         m_len           <= len_of(m_nx, m_last_c, m_rem_c);
         n_len           <= len_of(n_nx, n_last_c, n_rem_c);
         k_len           <= len_of(k_nx, k_last_c, k_rem_c);
         tile_accumulate <= acc_c || (k_nx != '0);
         last_k          <= (k_nx == k_last_c);
         last_tile       <= (k_nx == k_last_c) && (n_nx == n_last_c) && (m_nx == m_last_c);
      end
   end

endmodule

// File: rtl/gemm_cmd_sequencer.sv
// GEMM command responder: latches a start command, walks it as TILE^3
// sub-commands over valid/ready, and holds busy until every tile completes.
module gemm_cmd_sequencer
   import npu_ctrl_pkg::*;
#(
   parameter int unsigned TILE            = 8,
   parameter int unsigned DIM_WIDTH       = 16,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIM_WIDTH-1:0] dim_m,
   input  logic [DIM_WIDTH-1:0] dim_k,
   input  logic [DIM_WIDTH-1:0] dim_n,
   input  logic                 transpose_b,
   input  logic                 accumulate,
   input  logic [15:0]          imm,
   output logic                 busy,
   output logic                 done,
   output logic                 start_ignored,
   output logic                 tile_valid,
   input  logic                 tile_ready,
   output logic [DIM_WIDTH-1:0] tile_m_idx,
   output logic [DIM_WIDTH-1:0] tile_n_idx,
   output logic [DIM_WIDTH-1:0] tile_k_idx,
   output logic [DIM_WIDTH-1:0] tile_m_len,
   output logic [DIM_WIDTH-1:0] tile_n_len,
   output logic [DIM_WIDTH-1:0] tile_k_len,
   output logic                 tile_accumulate,
   output logic                 tile_last_k,
   output logic                 tile_transpose_b,
   output logic [15:0]          tile_imm,
   input  logic                 tile_done
);

   localparam int unsigned OUT_W = 4;

   gemm_seq_state_t      state_q, state_d;
   logic [OUT_W-1:0]     outst_q, outst_d;
   logic                 busy_d, done_d, start_ignored_d, tile_valid_d;
   logic                 tp_b_q;
   logic [IMM_W-1:0]     imm_q;
   logic                 accept, any_zero, xfer, retire;

   logic [DIM_WIDTH-1:0] cnt_m_idx, cnt_n_idx, cnt_k_idx;
   logic [DIM_WIDTH-1:0] cnt_m_len, cnt_n_len, cnt_k_len;
   logic                 cnt_acc, cnt_last_k, cnt_last_tile;
   tile_cmd_t            cmd;

   assign accept   = (state_q == GS_IDLE) && start;
   assign any_zero = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);
   assign xfer     = tile_valid && tile_ready;
   assign retire   = tile_done && (outst_q != '0);

   tile_loop_counter #(
      .TILE      (TILE),
      .DIM_WIDTH (DIM_WIDTH)
   ) u_loop (
      .clk             (clk),
      .rst_n           (rst_n),
      .load            (accept),
      .advance         (xfer),
      .dim_m           (dim_m),
      .dim_k           (dim_k),
      .dim_n           (dim_n),
      .accumulate      (accumulate),
      .m_idx           (cnt_m_idx),
      .n_idx           (cnt_n_idx),
      .k_idx           (cnt_k_idx),
      .m_len           (cnt_m_len),
      .n_len           (cnt_n_len),
      .k_len           (cnt_k_len),
      .tile_accumulate (cnt_acc),
      .last_k          (cnt_last_k),
      .last_tile       (cnt_last_tile)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= GS_IDLE;
      else        state_q <= state_d;
   end

   // A zero-sized job passes through DRAIN with nothing outstanding so that
   // busy is still visible for one cycle before done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         GS_IDLE:   if (start) state_d = any_zero ? GS_DRAIN : GS_ISSUE;
         GS_ISSUE:  if (xfer && cnt_last_tile) state_d = GS_DRAIN;
         GS_DRAIN:  if (outst_q == '0) state_d = GS_FINISH;
         GS_FINISH: state_d = GS_IDLE;
         default:   state_d = GS_IDLE;
      endcase
   end

   // Next values of the registered outputs and the in-flight count.
   always_comb begin
      outst_d         = outst_q + OUT_W'(xfer) - OUT_W'(retire);
      busy_d          = (state_d == GS_ISSUE) || (state_d == GS_DRAIN);
      done_d          = (state_d == GS_FINISH);
      start_ignored_d = start && (state_q != GS_IDLE);
      tile_valid_d    = (state_d == GS_ISSUE) && (outst_d < OUT_W'(MAX_OUTSTANDING));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_q       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         start_ignored <= 1'b0;
         tile_valid    <= 1'b0;
         tp_b_q        <= 1'b0;
         imm_q         <= '0;
      end else begin
         outst_q       <= outst_d;
         busy          <= busy_d;
         done          <= done_d;
         start_ignored <= start_ignored_d;
         tile_valid    <= tile_valid_d;
         if (accept) begin
            tp_b_q <= transpose_b;
            imm_q  <= imm;
         end
      end
   end

   assign cmd = '{
      m_idx:       CMD_DIM_W'(cnt_m_idx),
      n_idx:       CMD_DIM_W'(cnt_n_idx),
      k_idx:       CMD_DIM_W'(cnt_k_idx),
      m_len:       CMD_DIM_W'(cnt_m_len),
      n_len:       CMD_DIM_W'(cnt_n_len),
      k_len:       CMD_DIM_W'(cnt_k_len),
      accumulate:  cnt_acc,
      last_k:      cnt_last_k,
      transpose_b: tp_b_q,
      imm:         imm_q
   };

   assign tile_m_idx       = DIM_WIDTH'(cmd.m_idx);
   assign tile_n_idx       = DIM_WIDTH'(cmd.n_idx);
   assign tile_k_idx       = DIM_WIDTH'(cmd.k_idx);
   assign tile_m_len       = DIM_WIDTH'(cmd.m_len);
   assign tile_n_len       = DIM_WIDTH'(cmd.n_len);
   assign tile_k_len       = DIM_WIDTH'(cmd.k_len);
   assign tile_accumulate  = cmd.accumulate;
   assign tile_last_k      = cmd.last_k;
   assign tile_transpose_b = cmd.transpose_b;
   assign tile_imm         = cmd.imm;

endmodule

// File: tb/tb_gemm_cmd_sequencer.sv
// Directed bench for gemm_cmd_sequencer with TILE=8, MAX_OUTSTANDING=2.
module tb_gemm_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, start, transpose_b, accumulate, tile_ready, tile_done;
   logic [15:0] dim_m, dim_k, dim_n, imm;
   logic        busy, done, start_ignored, tile_valid;
   logic        tile_accumulate, tile_last_k, tile_transpose_b;
   logic [15:0] tile_m_idx, tile_n_idx, tile_k_idx, tile_m_len, tile_n_len, tile_k_len, tile_imm;

   typedef struct {
      int m_idx, n_idx, k_idx, m_len, n_len, k_len, acc, last_k;
   } rec_t;

   rec_t cap[$];
   int   done_q[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, tb_out = 0, done_cnt = 0, ign_cnt = 0, busy_cnt = 0, viol = 0;
   bit   auto_done = 1'b1, done_seen = 1'b0;

   gemm_cmd_sequencer #(.TILE(8), .DIM_WIDTH(16), .MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
      .transpose_b(transpose_b), .accumulate(accumulate), .imm(imm),
      .busy(busy), .done(done), .start_ignored(start_ignored),
      .tile_valid(tile_valid), .tile_ready(tile_ready),
      .tile_m_idx(tile_m_idx), .tile_n_idx(tile_n_idx), .tile_k_idx(tile_k_idx),
      .tile_m_len(tile_m_len), .tile_n_len(tile_n_len), .tile_k_len(tile_k_len),
      .tile_accumulate(tile_accumulate), .tile_last_k(tile_last_k),
      .tile_transpose_b(tile_transpose_b), .tile_imm(tile_imm), .tile_done(tile_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      cap.delete();
      done_cnt = 0; ign_cnt = 0; busy_cnt = 0; viol = 0; done_seen = 1'b0;
   endtask

   // One clock: log the transfer about to happen, advance, then update the array model.
   task automatic step();
      rec_t r;
      if (tile_valid && tile_ready) begin
         r.m_idx = tile_m_idx; r.n_idx = tile_n_idx; r.k_idx = tile_k_idx;
         r.m_len = tile_m_len; r.n_len = tile_n_len; r.k_len = tile_k_len;
         r.acc = tile_accumulate; r.last_k = tile_last_k;
         cap.push_back(r);
         if (auto_done) done_q.push_back(cyc + 3);
         tb_out++;
      end
      if (tile_done && tb_out > 0) tb_out--;
      @(posedge clk); #1;
      cyc++;
      tile_done = 1'b0;
      while (done_q.size() > 0 && done_q[0] <= cyc) begin
         if (done_q[0] == cyc) tile_done = 1'b1;
         void'(done_q.pop_front());
      end
      if (done) begin done_cnt++; done_seen = 1'b1; end
      if (start_ignored) ign_cnt++;
      if (busy) busy_cnt++;
      if (tile_valid && tb_out >= 2) viol++;
   endtask

   task automatic do_start(input int m, input int k, input int n, input bit acc);
      dim_m = 16'(m); dim_k = 16'(k); dim_n = 16'(n); accumulate = acc;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_until_done(input string tag);
      for (int i = 0; i < 200 && !done_seen; i++) step();
      chk({tag, "_done_seen"}, done_seen, 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      step();
      chk({tag, "_done_one_cycle"}, done, 0);
   endtask

   initial begin
      int em[6]  = '{0, 0, 0, 1, 1, 1};
      int ek[6]  = '{0, 1, 2, 0, 1, 2};
      int eml[6] = '{8, 8, 8, 2, 2, 2};
      int ekl[6] = '{8, 8, 4, 8, 8, 4};
      int ea[6]  = '{0, 1, 1, 0, 1, 1};
      int elk[6] = '{0, 0, 1, 0, 0, 1};
      rst_n = 1'b0; start = 1'b0; transpose_b = 1'b0; accumulate = 1'b0;
      tile_ready = 1'b1; tile_done = 1'b0;
      dim_m = '0; dim_k = '0; dim_n = '0; imm = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", tile_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_fields", |{tile_m_idx, tile_n_idx, tile_k_idx, tile_m_len, tile_n_len,
                          tile_k_len, tile_imm, tile_accumulate, tile_last_k, tile_transpose_b}, 0);
      rst_n = 1'b1;
      step();

      // 16x8x8: two tiles along m
      clr();
      transpose_b = 1'b1; imm = 16'hBEEF;
      do_start(16, 8, 8, 1'b0);
      chk("t1_busy_next", busy, 1);
      chk("t1_valid", tile_valid, 1);
      chk("t1_tp_b", tile_transpose_b, 1);
      chk("t1_imm", tile_imm, 32'hBEEF);
      run_until_done("t1");
      chk("t1_ntiles", cap.size(), 2);
      chk("t1_m0", cap[0].m_idx, 0);
      chk("t1_m1", cap[1].m_idx, 1);
      chk("t1_lens", cap[1].m_len + cap[1].n_len + cap[1].k_len, 24);
      chk("t1_acc", cap[0].acc + cap[1].acc, 0);
      chk("t1_last_k", cap[0].last_k + cap[1].last_k, 2);
      chk("t1_busy_cycles", busy_cnt, 6);
      chk("t1_done_cnt", done_cnt, 1);
      transpose_b = 1'b0; imm = '0;

      // 10x20x8: remainders on m and k
      clr();
      do_start(10, 20, 8, 1'b0);
      run_until_done("t2");
      chk("t2_ntiles", cap.size(), 6);
      for (int i = 0; i < 6 && i < cap.size(); i++) begin
         chk($sformatf("t2_m_idx%0d", i), cap[i].m_idx, em[i]);
         chk($sformatf("t2_k_idx%0d", i), cap[i].k_idx, ek[i]);
         chk($sformatf("t2_m_len%0d", i), cap[i].m_len, eml[i]);
         chk($sformatf("t2_k_len%0d", i), cap[i].k_len, ekl[i]);
         chk($sformatf("t2_n_len%0d", i), cap[i].n_len, 8);
         chk($sformatf("t2_acc%0d", i), cap[i].acc, ea[i]);
         chk($sformatf("t2_last_k%0d", i), cap[i].last_k, elk[i]);
      end

      // zero dimension: no tiles, busy one cycle, done at start+2
      clr();
      do_start(0, 8, 8, 1'b0);
      chk("t3_busy1", busy, 1);
      chk("t3_valid", tile_valid, 0);
      chk("t3_done1", done, 0);
      step();
      chk("t3_done2", done, 1);
      chk("t3_busy2", busy, 0);
      step();
      chk("t3_done3", done, 0);
      chk("t3_ntiles", cap.size(), 0);

      // backpressure and outstanding limit on 24x8x16
      clr();
      tile_ready = 1'b0; auto_done = 1'b0;
      do_start(24, 8, 16, 1'b0);
      repeat (4) step();
      chk("t4_valid_held", tile_valid, 1);
      chk("t4_stable_m", tile_m_idx, 0);
      chk("t4_stable_n", tile_n_idx, 0);
      chk("t4_stable_len", tile_m_len, 8);
      chk("t4_no_xfer", cap.size(), 0);
      tile_ready = 1'b1;
      repeat (4) step();
      chk("t4_two_xfers", cap.size(), 2);
      chk("t4_valid_low_full", tile_valid, 0);
      auto_done = 1'b1;
      done_q.push_back(cyc + 1);
      done_q.push_back(cyc + 2);
      run_until_done("t4");
      chk("t4_ntiles", cap.size(), 6);
      if (cap.size() >= 3) begin
         chk("t4_order_n", cap[1].n_idx, 1);
         chk("t4_order_m", cap[2].m_idx, 1);
      end
      chk("t4_viol", viol, 0);

      // ignored second start during ISSUE
      clr();
      do_start(10, 20, 8, 1'b0);
      step();
      do_start(8, 8, 8, 1'b1);
      chk("t5_ign_pulse", start_ignored, 1);
      step();
      chk("t5_ign_one_cycle", start_ignored, 0);
      run_until_done("t5");
      chk("t5_ign_cnt", ign_cnt, 1);
      chk("t5_ntiles", cap.size(), 6);
      if (cap.size() == 6) begin
         chk("t5_m_len3", cap[3].m_len, 2);
         chk("t5_k_len5", cap[5].k_len, 4);
         chk("t5_acc3", cap[3].acc, 0);
      end

      // reset mid-ISSUE, stale tile_done afterwards, then a fresh run
      clr();
      do_start(16, 16, 16, 1'b0);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", tile_valid, 0);
      chk("t6_rst_fields", |{tile_m_idx, tile_n_idx, tile_k_idx, tile_m_len, tile_n_len,
                             tile_k_len, tile_accumulate, tile_last_k}, 0);
      step();
      rst_n = 1'b1;
      tb_out = 0;
      clr();
      repeat (6) step();
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_valid", tile_valid, 0);
      chk("t6_no_done", done_cnt, 0);
      chk("t6_no_busy", busy_cnt, 0);
      do_start(8, 8, 8, 1'b0);
      chk("t6_restart_busy", busy, 1);
      run_until_done("t6");
      chk("t6_ntiles", cap.size(), 1);
      if (cap.size() == 1) chk("t6_last_k", cap[0].last_k, 1);
      chk("t6_done_cnt", done_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
